// File: rtl/isp_pkg.sv
// rtl/isp_pkg.sv - shared types, widths and sizing helpers for the padded frame sequencer
package isp_pkg;

    localparam int RGB_W = 24;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PRE   = 3'd1,
        ROW_L = 3'd2,
        ROW_D = 3'd3,
        ROW_R = 3'd4,
        POST  = 3'd5,
        FIN   = 3'd6
    } state_t;

    function automatic int calc_bw(input int kernel_size);
        return (kernel_size - 1) / 2;
    endfunction

    function automatic int calc_wp(input int active_width, input int kernel_size);
        return active_width + 2 * calc_bw(kernel_size);
    endfunction

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pad_frame_sequencer_if.sv
// rtl/pad_frame_sequencer_if.sv - pixel in/out and frame control bundle for pad_frame_sequencer
interface pad_frame_sequencer_if;
    import isp_pkg::*;

    logic             newFrame;
    logic             iValid;
    logic [RGB_W-1:0] iData;
    logic [RGB_W-1:0] oData;
    logic             oValid;
    logic             oStageReset;
    logic             oBusy;
    logic             oDone;
    logic             oOverrun;

    modport master (
        output newFrame, iValid, iData,
        input  oData, oValid, oStageReset, oBusy, oDone, oOverrun
    );

    modport slave (
        input  newFrame, iValid, iData,
        output oData, oValid, oStageReset, oBusy, oDone, oOverrun
    );

endinterface

// File: rtl/pad_fifo.sv
// rtl/pad_fifo.sv - single-clock pixel FIFO with head peek and same-cycle push/pop
module pad_fifo
    import isp_pkg::*;
#(
    parameter int DEPTH = 512,
    parameter int W     = RGB_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);

    localparam int AW = clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Storage write; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy tracking; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pad_frame_sequencer.sv
// rtl/pad_frame_sequencer.sv - wraps each frame in a BW-pixel border; option PAD_EDGE_REPLICATE_EN
module pad_frame_sequencer
    import isp_pkg::*;
#(
    parameter int width       = 320,
    parameter int height      = 240,
    parameter int KERNEL_SIZE = 3,
    parameter int FIFO_DEPTH  = 512
) (
    input  logic                  clk,
    input  logic                  reset,
    pad_frame_sequencer_if.slave  bus
);

    localparam int BW = calc_bw(KERNEL_SIZE);
    localparam int WP = calc_wp(width, KERNEL_SIZE);
    localparam int HP = height + 2 * BW;
    localparam int XW = clog2(WP);
    localparam int YW = clog2(HP);

    localparam logic [XW-1:0] X_L_LAST   = XW'(BW - 1);
    localparam logic [XW-1:0] X_D_LAST   = XW'(BW + width - 1);
    localparam logic [XW-1:0] X_LAST     = XW'(WP - 1);
    localparam logic [YW-1:0] Y_PRE_LAST = YW'(BW - 1);
    localparam logic [YW-1:0] Y_ROW_LAST = YW'(height + BW - 1);
    localparam logic [YW-1:0] Y_LAST     = YW'(HP - 1);

    state_t           state;
    state_t           state_nx;
    logic [XW-1:0]    xcnt;
    logic [XW-1:0]    xcnt_nx;
    logic [YW-1:0]    ycnt;
    logic [YW-1:0]    ycnt_nx;
    logic             beat;
    logic [RGB_W-1:0] beat_data;
    logic             pop;
    logic             stage_reset;
    logic             done;
    logic [RGB_W-1:0] fifo_head;
    logic             fifo_full;
    logic             fifo_empty;

    logic [RGB_W-1:0] odata;
    logic             ovalid;
    logic             ostage_reset;
    logic             obusy;
    logic             odone;
    logic             ooverrun;

    pad_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (RGB_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (bus.iValid),
        .push_data (bus.iData),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

`ifdef PAD_EDGE_REPLICATE_EN
    logic [RGB_W-1:0] last_pix;

    // Remember the last active pixel of the row so the right border can repeat it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_pix <= '0;
        end else if (pop) begin
            last_pix <= fifo_head;
        end
    end
`endif

    // State and position counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            xcnt  <= '0;
            ycnt  <= '0;
        end else begin
            state <= state_nx;
            xcnt  <= xcnt_nx;
            ycnt  <= ycnt_nx;
        end
    end

    // Next state, beat decision and pixel selection; counters only move on an emitted beat.
    always_comb begin
        state_nx    = state;
        xcnt_nx     = xcnt;
        ycnt_nx     = ycnt;
        beat        = 1'b0;
        beat_data   = '0;
        pop         = 1'b0;
        stage_reset = 1'b0;
        done        = 1'b0;
        case (state)
            IDLE: begin
                if (bus.newFrame) begin
                    state_nx    = PRE;
                    stage_reset = 1'b1;
                    xcnt_nx     = '0;
                    ycnt_nx     = '0;
                end
            end
            PRE: begin
                beat = 1'b1;
                if (xcnt == X_LAST) begin
                    xcnt_nx = '0;
                    ycnt_nx = ycnt + 1'b1;
                    if (ycnt == Y_PRE_LAST) begin
                        state_nx = ROW_L;
                    end
                end else begin
                    xcnt_nx = xcnt + 1'b1;
                end
            end
            ROW_L: begin
`ifdef PAD_EDGE_REPLICATE_EN
                beat      = !fifo_empty;
                beat_data = fifo_head;
`else
                beat      = 1'b1;
`endif
                if (beat) begin
                    xcnt_nx = xcnt + 1'b1;
                    if (xcnt == X_L_LAST) begin
                        state_nx = ROW_D;
                    end
                end
            end
            ROW_D: begin
                if (!fifo_empty) begin
                    beat      = 1'b1;
                    pop       = 1'b1;
                    beat_data = fifo_head;
                    xcnt_nx   = xcnt + 1'b1;
                    if (xcnt == X_D_LAST) begin
                        state_nx = ROW_R;
                    end
                end
            end
            ROW_R: begin
                beat = 1'b1;
`ifdef PAD_EDGE_REPLICATE_EN
                beat_data = last_pix;
`endif
                if (xcnt == X_LAST) begin
                    xcnt_nx  = '0;
                    ycnt_nx  = ycnt + 1'b1;
                    state_nx = (ycnt == Y_ROW_LAST) ? POST : ROW_L;
                end else begin
                    xcnt_nx = xcnt + 1'b1;
                end
            end
            POST: begin
                beat = 1'b1;
                if (xcnt == X_LAST) begin
                    xcnt_nx = '0;
                    if (ycnt == Y_LAST) begin
                        state_nx = FIN;
                        ycnt_nx  = '0;
                    end else begin
                        ycnt_nx = ycnt + 1'b1;
                    end
                end else begin
                    xcnt_nx = xcnt + 1'b1;
                end
            end
            FIN: begin
                done     = 1'b1;
                state_nx = IDLE;
                xcnt_nx  = '0;
                ycnt_nx  = '0;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Registered outputs; overrun is sticky until reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            odata        <= '0;
            ovalid       <= 1'b0;
            ostage_reset <= 1'b0;
            obusy        <= 1'b0;
            odone        <= 1'b0;
            ooverrun     <= 1'b0;
        end else begin
            odata        <= beat_data;
            ovalid       <= beat;
            ostage_reset <= stage_reset;
            obusy        <= (state_nx != IDLE);
            odone        <= done;
            ooverrun     <= ooverrun
                          | (bus.newFrame && (state != IDLE))
                          | (bus.iValid && fifo_full && !pop);
        end
    end

    assign bus.oData       = odata;
    assign bus.oValid      = ovalid;
    assign bus.oStageReset = ostage_reset;
    assign bus.oBusy       = obusy;
    assign bus.oDone       = odone;
    assign bus.oOverrun    = ooverrun;

endmodule
